// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer/transmitter handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NB_DATA = 8,
    parameter int N_REQ   = 4
);
    logic [N_REQ-1:0]         i_req;
    logic [N_REQ*NB_DATA-1:0] i_data;
    logic                     i_tick;
    logic                     i_tx_done;
    logic [NB_DATA-1:0]       o_tx_data;
    logic                     o_tx_start;
    logic [N_REQ-1:0]         o_grant;
    logic [N_REQ-1:0]         o_ack;
    logic                     o_busy;
    logic                     o_error;

    modport slave (
        input  i_req, i_data, i_tick, i_tx_done,
        output o_tx_data, o_tx_start, o_grant, o_ack, o_busy, o_error
    );

    modport master (
        output i_req, i_data, i_tick, i_tx_done,
        input  o_tx_data, o_tx_start, o_grant, o_ack, o_busy, o_error
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among N_REQ byte producers
module uart_tx_arbiter #(
    parameter int NB_DATA    = 8,
    parameter int N_REQ      = 4,
    parameter int LOG2_N_REQ = 2,
    parameter int MAX_WAIT   = 4096,
    parameter int NB_WAIT    = 13
) (
    input  logic              i_clock,
    input  logic              i_reset,
    uart_tx_arbiter_if.slave  io_bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } state_t;

    localparam logic [NB_WAIT-1:0]    WAIT_LAST = NB_WAIT'(MAX_WAIT - 1);
    localparam logic [LOG2_N_REQ-1:0] LAST_RST  = LOG2_N_REQ'(N_REQ - 1);

    state_t                  r_state;
    logic [LOG2_N_REQ-1:0]   r_last;
    logic [LOG2_N_REQ-1:0]   r_sel;
    logic [NB_DATA-1:0]      r_tx_data;
    logic                    r_tx_start;
    logic [N_REQ-1:0]        r_grant;
    logic [N_REQ-1:0]        r_ack;
    logic                    r_busy;
    logic                    r_error;
    logic [NB_WAIT-1:0]      r_wait_cnt;
    logic                    r_done_q;

    logic                    w_found;
    logic [LOG2_N_REQ-1:0]   w_sel;
    logic [N_REQ-1:0]        w_onehot;
    logic [NB_DATA-1:0]      w_data;
    logic                    w_done_edge;

    // Rotating search: first active request at or after last+1, wrapping at N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = int'(r_last) + 1 + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && io_bus.i_req[idx]) begin
                w_found = 1'b1;
                w_sel   = LOG2_N_REQ'(idx);
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_sel] = 1'b1;
        w_data          = io_bus.i_data[int'(w_sel)*NB_DATA +: NB_DATA];
    end

    // A done level already high on entry to WAIT_DONE must not count as completion.
    assign w_done_edge = io_bus.i_tx_done & ~r_done_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_last     <= LAST_RST;
            r_sel      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
            r_wait_cnt <= '0;
            r_done_q   <= 1'b0;
        end else begin
            r_done_q <= io_bus.i_tx_done;
            r_ack    <= '0;
            r_error  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel      <= w_sel;
                        r_tx_data  <= w_data;
                        r_grant    <= w_onehot;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    // uart_tx samples start only on its valid tick, so hold until one arrives.
                    if (io_bus.i_tick) begin
                        r_tx_start <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    r_wait_cnt <= r_wait_cnt + NB_WAIT'(1);
                    if (w_done_edge || (r_wait_cnt == WAIT_LAST)) begin
                        r_ack   <= r_grant;
                        r_error <= ~w_done_edge;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_last  <= r_sel;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.o_tx_data  = r_tx_data;
    assign io_bus.o_tx_start = r_tx_start;
    assign io_bus.o_grant    = r_grant;
    assign io_bus.o_ack      = r_ack;
    assign io_bus.o_busy     = r_busy;
    assign io_bus.o_error    = r_error;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NB_DATA    = 8;
    localparam int N_REQ      = 4;
    localparam int LOG2_N_REQ = 2;
    localparam int MAX_WAIT   = 64;
    localparam int NB_WAIT    = 7;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NB_DATA(NB_DATA), .N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(
        .NB_DATA(NB_DATA), .N_REQ(N_REQ), .LOG2_N_REQ(LOG2_N_REQ),
        .MAX_WAIT(MAX_WAIT), .NB_WAIT(NB_WAIT)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .io_bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.i_req     = '0;
        bus.i_data    = '0;
        bus.i_tick    = 1'b0;
        bus.i_tx_done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.i_req     = 4'b1111;
        bus.i_data    = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.i_tick    = 1'b1;
        bus.i_tx_done = 1'b0;
        step();
        step();
        n_cmp++; if (bus.o_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", bus.o_tx_data); end
        n_cmp++; if (bus.o_tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", bus.o_tx_start); end
        n_cmp++; if (bus.o_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", bus.o_grant); end
        n_cmp++; if (bus.o_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", bus.o_ack); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        n_cmp++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", bus.o_error); end
        rst = 1'b0;
        step();
        n_cmp++; if (bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", bus.o_grant); end
        n_cmp++; if (bus.o_tx_data !== 8'h11) begin n_fail++; $display("FAIL reset_first_data: got %h expected 11", bus.o_tx_data); end
    endtask

    task automatic test_single();
        apply_reset();
        bus.i_data = {8'h00, 8'h00, 8'h00, 8'hA5};
        bus.i_req  = 4'b0001;
        step();
        n_cmp++; if (bus.o_tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", bus.o_tx_start); end
        n_cmp++; if (bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", bus.o_grant); end
        n_cmp++; if (bus.o_tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", bus.o_tx_data); end
        n_cmp++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", bus.o_busy); end
        for (int i = 0; i < 15; i++) step();
        bus.i_tick = 1'b1;
        n_cmp++; if (bus.o_tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start_on_tick: got %b expected 1", bus.o_tx_start); end
        step();
        bus.i_tick = 1'b0;
        n_cmp++; if (bus.o_tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_drop: got %b expected 0", bus.o_tx_start); end
        for (int i = 0; i < 10; i++) step();
        n_cmp++; if (bus.o_ack !== 4'b0000) begin n_fail++; $display("FAIL single_early_ack: got %b expected 0000", bus.o_ack); end
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
        n_cmp++; if (bus.o_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", bus.o_ack); end
        n_cmp++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL single_error: got %b expected 0", bus.o_error); end
        bus.i_req = 4'b0000;
        step();
        n_cmp++; if (bus.o_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected 0000", bus.o_ack); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", bus.o_busy); end
        n_cmp++; if (bus.o_grant !== 4'b0000) begin n_fail++; $display("FAIL single_idle_grant: got %b expected 0000", bus.o_grant); end
        n_cmp++; if (bus.o_tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold: got %h expected a5", bus.o_tx_data); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.i_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.i_req  = 4'b1111;
        for (int s = 0; s < 6; s++) begin
            int         k;
            int         waited;
            logic [3:0] oh;
            logic [7:0] byte_exp;
            k        = s % 4;
            oh       = 4'b0001 << k;
            byte_exp = 8'h10 + 8'(k);
            waited   = 0;
            step();
            while (!bus.o_tx_start && waited < 8) begin
                step();
                waited++;
            end
            n_cmp++; if (bus.o_tx_start !== 1'b1) begin n_fail++; $display("FAIL rr_start[%0d]: got %b expected 1", s, bus.o_tx_start); end
            n_cmp++; if (bus.o_grant !== oh) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", s, bus.o_grant, oh); end
            n_cmp++; if (bus.o_tx_data !== byte_exp) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", s, bus.o_tx_data, byte_exp); end
            bus.i_tick = 1'b1;
            step();
            bus.i_tick    = 1'b0;
            bus.i_tx_done = 1'b1;
            step();
            bus.i_tx_done = 1'b0;
            n_cmp++; if (bus.o_ack !== oh) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", s, bus.o_ack, oh); end
            bus.i_req[k] = 1'b0;
            step();
            bus.i_req[k] = 1'b1;
        end
        bus.i_req = 4'b0000;
        step();
    endtask

    task automatic test_tick_align();
        int high_cycles;
        apply_reset();
        bus.i_data = {8'h00, 8'h00, 8'h00, 8'h5C};
        bus.i_req  = 4'b0001;
        step();
        high_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.o_tx_start === 1'b1) high_cycles++;
            step();
        end
        bus.i_tick = 1'b1;
        if (bus.o_tx_start === 1'b1) high_cycles++;
        n_cmp++; if (high_cycles !== 51) begin n_fail++; $display("FAIL tick_start_cycles: got %0d expected 51", high_cycles); end
        step();
        bus.i_tick = 1'b0;
        n_cmp++; if (bus.o_tx_start !== 1'b0) begin n_fail++; $display("FAIL tick_start_drop: got %b expected 0", bus.o_tx_start); end
        n_cmp++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL tick_wait_busy: got %b expected 1", bus.o_busy); end
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
        n_cmp++; if (bus.o_ack !== 4'b0001) begin n_fail++; $display("FAIL tick_ack: got %b expected 0001", bus.o_ack); end
        bus.i_req = 4'b0000;
        step();
    endtask

    task automatic test_sticky_done();
        int k;
        apply_reset();
        bus.i_data = {8'h00, 8'h00, 8'h77, 8'h00};
        bus.i_req  = 4'b0010;
        step();
        n_cmp++; if (bus.o_grant !== 4'b0010) begin n_fail++; $display("FAIL sticky_grant: got %b expected 0010", bus.o_grant); end
        bus.i_tick    = 1'b1;
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tick = 1'b0;
        k = 0;
        while (bus.o_ack === 4'b0000 && k < 100) begin
            step();
            k++;
        end
        n_cmp++; if (k !== 64) begin n_fail++; $display("FAIL sticky_timeout_cycles: got %0d expected 64", k); end
        n_cmp++; if (bus.o_ack !== 4'b0010) begin n_fail++; $display("FAIL sticky_ack: got %b expected 0010", bus.o_ack); end
        n_cmp++; if (bus.o_error !== 1'b1) begin n_fail++; $display("FAIL sticky_error: got %b expected 1", bus.o_error); end
        bus.i_req     = 4'b0000;
        bus.i_tx_done = 1'b0;
        step();
        n_cmp++; if (bus.o_error !== 1'b0) begin n_fail++; $display("FAIL sticky_error_pulse: got %b expected 0", bus.o_error); end
    endtask

    task automatic test_withdraw();
        apply_reset();
        bus.i_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.i_req  = 4'b0100;
        step();
        n_cmp++; if (bus.o_grant !== 4'b0100) begin n_fail++; $display("FAIL wd_grant: got %b expected 0100", bus.o_grant); end
        bus.i_tick = 1'b1;
        step();
        bus.i_tick = 1'b0;
        bus.i_req  = 4'b1001;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (bus.o_grant !== 4'b0100) begin n_fail++; $display("FAIL wd_grant_hold: got %b expected 0100", bus.o_grant); end
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
        n_cmp++; if (bus.o_ack !== 4'b0100) begin n_fail++; $display("FAIL wd_ack: got %b expected 0100", bus.o_ack); end
        step();
        step();
        n_cmp++; if (bus.o_grant !== 4'b1000) begin n_fail++; $display("FAIL wd_next_grant: got %b expected 1000", bus.o_grant); end
        n_cmp++; if (bus.o_tx_data !== 8'hD3) begin n_fail++; $display("FAIL wd_next_data: got %h expected d3", bus.o_tx_data); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.i_data = {8'h00, 8'h00, 8'h66, 8'h55};
        bus.i_req  = 4'b0010;
        step();
        bus.i_tick = 1'b1;
        step();
        bus.i_tick = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst       = 1'b1;
        bus.i_req = 4'b0011;
        step();
        rst = 1'b0;
        n_cmp++; if (bus.o_ack !== 4'b0000) begin n_fail++; $display("FAIL mid_ack: got %b expected 0000", bus.o_ack); end
        n_cmp++; if (bus.o_grant !== 4'b0000) begin n_fail++; $display("FAIL mid_grant: got %b expected 0000", bus.o_grant); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", bus.o_busy); end
        n_cmp++; if (bus.o_tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data: got %h expected 00", bus.o_tx_data); end
        n_cmp++; if (bus.o_tx_start !== 1'b0) begin n_fail++; $display("FAIL mid_tx_start: got %b expected 0", bus.o_tx_start); end
        step();
        n_cmp++; if (bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL mid_favour0: got %b expected 0001", bus.o_grant); end
        bus.i_req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_tick_align();
        test_sticky_done();
        test_withdraw();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
